// File: rtl/instr_encoder_loader.sv
// Program loader: packs symbolic ADDI/BNE instructions into RV32I words and streams each word
// little-endian, one byte per cycle, into byte-wide instruction memory starting at BASE_ADDR.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic signed [12:0]    imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic [31:0]           instr_word,
  output logic                  err,
  output logic [ADDR_WIDTH-2:0] count,
  output logic                  full
);
  localparam int CAP = ((2 ** ADDR_WIDTH) - BASE_ADDR) / 4;
  localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-2:0] CAP_CNT = (ADDR_WIDTH-1)'(CAP);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [31:0]             instr_word_q, instr_word_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-2:0]   count_q, count_d;
  logic                    full_q, full_d;

  function automatic logic [31:0] encode(input logic [1:0] f_op, input logic [4:0] f_rd,
                                         input logic [4:0] f_rs1, input logic [4:0] f_rs2,
                                         input logic signed [12:0] f_imm);
    if (f_op == 2'b01)
      encode = {f_imm[12], f_imm[10:5], f_rs2, f_rs1, 3'b001, f_imm[4:1], f_imm[11], 7'b1100011};
    else
      encode = {f_imm[11:0], f_rs1, 3'b000, f_rd, 7'b0010011};
  endfunction

  // Undefined opcode, ADDI immediate outside 12-bit signed range, or odd branch offset.
  function automatic logic is_rejected(input logic [1:0] f_op, input logic signed [12:0] f_imm);
    is_rejected = f_op[1]
               || ((f_op == 2'b00) && (f_imm[12] != f_imm[11]))
               || ((f_op == 2'b01) && f_imm[0]);
  endfunction

  assign in_ready   = (state_q == IDLE) && !full_q;
  assign mem_we     = (state_q == WRITE);
  assign mem_addr   = wr_ptr_q + {{(ADDR_WIDTH-2){1'b0}}, byte_idx_q};
  assign instr_word = instr_word_q;
  assign err        = err_q;
  assign count      = count_q;
  assign full       = full_q;

  always_comb begin
    mem_wdata = 8'h00;
    if (state_q == WRITE) begin
      case (byte_idx_q)
        2'd0:    mem_wdata = instr_word_q[7:0];
        2'd1:    mem_wdata = instr_word_q[15:8];
        2'd2:    mem_wdata = instr_word_q[23:16];
        default: mem_wdata = instr_word_q[31:24];
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    byte_idx_d   = byte_idx_q;
    instr_word_d = instr_word_q;
    err_d        = 1'b0;
    count_d      = count_q;
    full_d       = full_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (is_rejected(op, imm)) begin
            err_d = 1'b1;
          end else begin
            instr_word_d = encode(op, rd, rs1, rs2, imm);
            byte_idx_d   = 2'd0;
            state_d      = WRITE;
          end
        end
      end
      WRITE: begin
        if (byte_idx_q == 2'd3) begin
          byte_idx_d = 2'd0;
          count_d    = count_q + 1'b1;
          state_d    = IDLE;
          // The pointer parks on the last slot once full so it can never wrap.
          if (count_d == CAP_CNT) full_d = 1'b1;
          else                    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(4);
        end else begin
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= BASE;
      byte_idx_q   <= 2'd0;
      instr_word_q <= 32'h0;
      err_q        <= 1'b0;
      count_q      <= '0;
      full_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      byte_idx_q   <= byte_idx_d;
      instr_word_q <= instr_word_d;
      err_q        <= err_d;
      count_q      <= count_d;
      full_q       <= full_d;
    end
  end

endmodule
